ifu: RTL and testbench
======================

# ifu

Instruction fetch unit for the RV64 multicycle core; sits directly upstream of the decode stage. Holds the architectural PC and issues one 32-bit fetch per instruction on the instruction bus. Presents the fetched word plus its PC to decode with a one-cycle `idu_valid` pulse, then waits for the core to finish the instruction before computing the next PC (sequential, branch target, or flush target).

## Interface
- `RESET_PC`, 64'h8000_0000: PC after reset.
- `clk` in 1: sole clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `ireq_valid` out 1: fetch request; held high until `iresp_ready`.
- `ireq_addr` out 64: fetch address; stable while `ireq_valid` is high.
- `iresp_ready` in 1: response handshake; data valid this cycle.
- `iresp_data` in 32: instruction word.
- `wb_done` in 1: current instruction completed (one-cycle pulse).
- `br_taken` in 1: sampled with `wb_done`; select `br_target`.
- `br_target` in 64: branch/jump target.
- `flush` in 1: redirect (trap/return); highest priority.
- `flush_pc` in 64: redirect target.
- `instr` out 32: fetched instruction to decode.
- `pc` out 64: PC of `instr`.
- `idu_valid` out 1: one-cycle pulse; `instr`/`pc` newly valid.
- `fetch_err` out 1: sticky misaligned-target error.
- `fetch_cnt` out 64: count of `idu_valid` pulses; wraps mod 2^64.

## Operation
- States: IDLE, FETCH, EXEC, DRAIN, ERR.
- IDLE: entered on reset. Goes to FETCH next cycle.
- FETCH: `ireq_valid`=1, `ireq_addr`=`req_addr`.
  - On `iresp_ready` without `flush`: latch `instr`<=`iresp_data` and `pc`<=`req_addr`; pulse `idu_valid` next cycle; increment `fetch_cnt`; go to EXEC.
  - On `iresp_ready` with `flush`: discard data; `req_addr`<=`flush_pc`; stay in FETCH; no pulse.
  - On `flush` without `iresp_ready`: store `flush_pc` in `pend_pc`; go to DRAIN.
- DRAIN: `ireq_valid`=1 with the old `ireq_addr`.
  - On `iresp_ready`: discard data; `req_addr`<=`pend_pc`; go to FETCH.
  - A further `flush` in DRAIN overwrites `pend_pc`; last one wins.
- EXEC: `ireq_valid`=0.
  - On `flush`: next = `flush_pc`. `flush` overrides a simultaneous `wb_done`.
  - Else on `wb_done`: next = `br_taken` ? `br_target` : `pc`+4. Addition is 64-bit, wraps.
  - If next[1:0]!=0: go to ERR and set `fetch_err`. Else `req_addr`<=next and go to FETCH.
- ERR: `ireq_valid`=0; `fetch_err`=1.
  - `flush` with aligned `flush_pc` clears `fetch_err`, loads `req_addr`, goes to FETCH.
  - Misaligned `flush_pc` stays in ERR.
- Misaligned `flush_pc` in FETCH/DRAIN: bus transaction completes first, then go to ERR.
- `wb_done` outside EXEC is ignored.

## Timing
- Reset values:
  - `ireq_valid`=0, `ireq_addr`=`RESET_PC`, `pc`=`RESET_PC`.
  - `instr`=0, `idu_valid`=0, `fetch_err`=0, `fetch_cnt`=0, state IDLE.
- `rst` has priority over every input, in every state, including mid-request; any outstanding bus response is dropped.
- First `ireq_valid` is high in the 2nd cycle after `rst` falls.
- Handshake in cycle N: `instr`, `pc`, `idu_valid` visible in N+1; `idu_valid` low in N+2.
- `wb_done`/`flush` in EXEC at cycle M: `ireq_valid` high with the new address in M+1.
- Best-case fetch-to-fetch with zero-wait memory: 3 cycles (FETCH, EXEC entry, `wb_done`).
- `ireq_valid` never drops and `ireq_addr` never changes before `iresp_ready`.
- All outputs are registered. `ireq_valid` is decoded from the state register only.

## Structure
- Shared package (`param.sv`):
  - `ifu_state_t` enum.
  - `` `RESET_PC `` default.
  - `` `ILEN `` (32) and `` `XLEN `` (64).
- Sub-module `ifu_pcgen`: combinational next-PC mux, +4 adder, and misalignment check. Inputs: `pc`, `br_taken`, `br_target`, `flush`, `flush_pc`. Outputs: `next_pc`, `misaligned`.
- FSM, `req_addr`/`pend_pc` registers, and counter live in `ifu`.

## Test plan
- Reset, zero-wait memory returning 32'h00000013 -> `ireq_addr`=8000_0000 in cycle 2; `idu_valid` pulse with `pc`=8000_0000, `instr`=00000013; `fetch_cnt`=1.
- `wb_done` with `br_taken`=0, then `wb_done` with `br_taken`=1, `br_target`=8000_0100 -> fetch addresses 8000_0004 then 8000_0100.
- 3-cycle wait memory; `flush` to 8000_0200 in wait cycle 1 -> address stays 8000_0004 until response; no `idu_valid`; next request at 8000_0200.
- `flush` and `wb_done` together in EXEC -> next fetch at `flush_pc`, not `pc`+4.
- `br_target`=8000_0102 -> ERR, `fetch_err`=1, no requests; `flush` to 8000_0000 -> `fetch_err`=0, fetch resumes.
- `rst` asserted while `ireq_valid` waits -> next cycle `ireq_valid`=0, all outputs at reset values.

Source files
------------

// File: rtl/ifu_pkg.sv
// ifu_pkg: shared types and constants for the instruction fetch unit.
//   XLEN             - architectural register / address width (64)
//   ILEN             - instruction word width (32)
//   RESET_PC_DEFAULT - default PC loaded on reset
//   ifu_state_t      - fetch FSM state encoding
package ifu_pkg;

    localparam int XLEN = 64;
    localparam int ILEN = 32;

    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 64'h0000_0000_8000_0000;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_EXEC  = 3'd2,
        S_DRAIN = 3'd3,
        S_ERR   = 3'd4
    } ifu_state_t;

endpackage

// File: rtl/ifu_pcgen.sv
// ifu_pcgen: combinational next-PC selection for the fetch unit.
//   pc         in  - PC of the instruction that is finishing
//   br_taken   in  - select br_target instead of pc+4
//   br_target  in  - branch/jump target
//   flush      in  - redirect request, overrides everything else
//   flush_pc   in  - redirect target
//   next_pc    out - selected next fetch address
//   misaligned out - next_pc is not 4-byte aligned
import ifu_pkg::*;

module ifu_pcgen (
    input  logic [XLEN-1:0] pc,
    input  logic            br_taken,
    input  logic [XLEN-1:0] br_target,
    input  logic            flush,
    input  logic [XLEN-1:0] flush_pc,
    output logic [XLEN-1:0] next_pc,
    output logic            misaligned
);

    always_comb begin
        if (flush) begin
            next_pc = flush_pc;
        end else if (br_taken) begin
            next_pc = br_target;
        end else begin
            // 64-bit add, wraps naturally at the top of the address space
            next_pc = pc + XLEN'(4);
        end
        misaligned = (next_pc[1:0] != 2'b00);
    end

endmodule

// File: rtl/ifu.sv
// ifu: instruction fetch unit. Holds the PC, issues one 32-bit fetch per
// instruction, hands the word to decode with a one-cycle idu_valid pulse and
// waits for writeback (or a flush) before computing the next fetch address.
//   clk, rst     in  - clock, synchronous active-high reset
//   ireq_valid   out - fetch request, held until iresp_ready
//   ireq_addr    out - fetch address, stable while ireq_valid
//   iresp_ready  in  - response handshake, iresp_data valid this cycle
//   iresp_data   in  - fetched instruction word
//   wb_done      in  - current instruction completed (pulse)
//   br_taken     in  - with wb_done: use br_target
//   br_target    in  - branch/jump target
//   flush        in  - redirect, highest priority
//   flush_pc     in  - redirect target
//   instr, pc    out - fetched word and its PC
//   idu_valid    out - one-cycle pulse, instr/pc newly valid
//   fetch_err    out - sticky misaligned-target error
//   fetch_cnt    out - number of idu_valid pulses (wraps)
import ifu_pkg::*;

module ifu #(
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    output logic            ireq_valid,
    output logic [XLEN-1:0] ireq_addr,
    input  logic            iresp_ready,
    input  logic [ILEN-1:0] iresp_data,
    input  logic            wb_done,
    input  logic            br_taken,
    input  logic [XLEN-1:0] br_target,
    input  logic            flush,
    input  logic [XLEN-1:0] flush_pc,
    output logic [ILEN-1:0] instr,
    output logic [XLEN-1:0] pc,
    output logic            idu_valid,
    output logic            fetch_err,
    output logic [XLEN-1:0] fetch_cnt
);

    ifu_state_t      state_reg, state_next;
    logic [XLEN-1:0] req_addr_reg, req_addr_next;
    logic [XLEN-1:0] pend_pc_reg, pend_pc_next;
    logic            fetch_err_reg, fetch_err_next;
    logic [ILEN-1:0] instr_reg;
    logic [XLEN-1:0] pc_reg;
    logic            idu_valid_reg;
    logic [XLEN-1:0] fetch_cnt_reg;
    logic            capture;
    logic [XLEN-1:0] redirect;
    logic [XLEN-1:0] gen_next_pc;
    logic            gen_misaligned;

    ifu_pcgen u_pcgen (
        .pc         (pc_reg),
        .br_taken   (br_taken),
        .br_target  (br_target),
        .flush      (flush),
        .flush_pc   (flush_pc),
        .next_pc    (gen_next_pc),
        .misaligned (gen_misaligned)
    );

    always_comb begin
        state_next     = state_reg;
        req_addr_next  = req_addr_reg;
        pend_pc_next   = pend_pc_reg;
        fetch_err_next = fetch_err_reg;
        capture        = 1'b0;
        redirect       = pend_pc_reg;
        case (state_reg)
            S_IDLE: state_next = S_FETCH;
            S_FETCH: begin
                if (iresp_ready) begin
                    if (flush) begin
                        // Response arrived together with a redirect: drop the
                        // word and refetch from the redirect target.
                        if (flush_pc[1:0] != 2'b00) begin
                            state_next     = S_ERR;
                            fetch_err_next = 1'b1;
                        end else begin
                            req_addr_next = flush_pc;
                        end
                    end else begin
                        capture    = 1'b1;
                        state_next = S_EXEC;
                    end
                end else if (flush) begin
                    // The bus transaction cannot be abandoned; remember the
                    // target and wait for the stale response.
                    pend_pc_next = flush_pc;
                    state_next   = S_DRAIN;
                end
            end
            S_DRAIN: begin
                // A flush coinciding with the response is the newest target.
                redirect = flush ? flush_pc : pend_pc_reg;
                if (flush) begin
                    pend_pc_next = flush_pc;
                end
                if (iresp_ready) begin
                    if (redirect[1:0] != 2'b00) begin
                        state_next     = S_ERR;
                        fetch_err_next = 1'b1;
                    end else begin
                        req_addr_next = redirect;
                        state_next    = S_FETCH;
                    end
                end
            end
            S_EXEC: begin
                if (flush || wb_done) begin
                    if (gen_misaligned) begin
                        state_next     = S_ERR;
                        fetch_err_next = 1'b1;
                    end else begin
                        req_addr_next = gen_next_pc;
                        state_next    = S_FETCH;
                    end
                end
            end
            S_ERR: begin
                // pcgen selects flush_pc whenever flush is high
                if (flush && !gen_misaligned) begin
                    req_addr_next  = gen_next_pc;
                    fetch_err_next = 1'b0;
                    state_next     = S_FETCH;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= S_IDLE;
            req_addr_reg  <= RESET_PC;
            pend_pc_reg   <= RESET_PC;
            fetch_err_reg <= 1'b0;
            instr_reg     <= '0;
            pc_reg        <= RESET_PC;
            idu_valid_reg <= 1'b0;
            fetch_cnt_reg <= '0;
        end else begin
            state_reg     <= state_next;
            req_addr_reg  <= req_addr_next;
            pend_pc_reg   <= pend_pc_next;
            fetch_err_reg <= fetch_err_next;
            idu_valid_reg <= capture;
            if (capture) begin
                instr_reg     <= iresp_data;
                pc_reg        <= req_addr_reg;
                fetch_cnt_reg <= fetch_cnt_reg + XLEN'(1);
            end
        end
    end

    assign ireq_valid = (state_reg == S_FETCH) || (state_reg == S_DRAIN);
    assign ireq_addr  = req_addr_reg;
    assign instr      = instr_reg;
    assign pc         = pc_reg;
    assign idu_valid  = idu_valid_reg;
    assign fetch_err  = fetch_err_reg;
    assign fetch_cnt  = fetch_cnt_reg;

endmodule

// File: tb/tb_ifu.sv
// tb_ifu: scoreboard bench for ifu. The stimulus process pushes expected
// fetch addresses and decode handoffs into queues; a monitor pops and
// compares them whenever the DUT handshakes or pulses idu_valid. A small
// memory model answers requests after a programmable number of wait cycles,
// returning {addr[19:0], 12'h013}.
module tb_ifu;

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] instr;
        logic [63:0] cnt;
    } idu_exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        ireq_valid;
    logic [63:0] ireq_addr;
    logic        iresp_ready;
    logic [31:0] iresp_data;
    logic        wb_done;
    logic        br_taken;
    logic [63:0] br_target;
    logic        flush;
    logic [63:0] flush_pc;
    logic [31:0] instr;
    logic [63:0] pc;
    logic        idu_valid;
    logic        fetch_err;
    logic [63:0] fetch_cnt;

    int n_checks = 0;
    int n_fail   = 0;
    int mem_wait = 0;
    int wcnt     = 0;

    logic [63:0] exp_addr[$];
    idu_exp_t    exp_idu[$];

    ifu #(.RESET_PC(64'h8000_0000)) dut (
        .clk         (clk),
        .rst         (rst),
        .ireq_valid  (ireq_valid),
        .ireq_addr   (ireq_addr),
        .iresp_ready (iresp_ready),
        .iresp_data  (iresp_data),
        .wb_done     (wb_done),
        .br_taken    (br_taken),
        .br_target   (br_target),
        .flush       (flush),
        .flush_pc    (flush_pc),
        .instr       (instr),
        .pc          (pc),
        .idu_valid   (idu_valid),
        .fetch_err   (fetch_err),
        .fetch_cnt   (fetch_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Memory model: decides at negedge+1 what iresp_ready will be at the next posedge.
    initial begin
        iresp_ready = 1'b0;
        iresp_data  = '0;
        forever begin
            @(negedge clk);
            #1;
            if (rst || !ireq_valid || iresp_ready) begin
                iresp_ready = 1'b0;
                wcnt        = 0;
            end else if (wcnt >= mem_wait) begin
                iresp_ready = 1'b1;
                iresp_data  = {ireq_addr[19:0], 12'h013};
            end else begin
                wcnt++;
            end
        end
    end

    // Monitor: sampled at negedge+2, after the memory model has settled.
    initial begin
        logic        prev_pending;
        logic [63:0] prev_addr;
        logic        prev_idu;
        idu_exp_t    e;
        prev_pending = 1'b0;
        prev_addr    = '0;
        prev_idu     = 1'b0;
        forever begin
            @(negedge clk);
            #2;
            if (prev_pending) begin
                chk("req_hold_valid", {63'd0, ireq_valid}, 64'd1);
                chk("req_hold_addr", ireq_addr, prev_addr);
            end
            if (prev_idu) begin
                chk("idu_pulse_width", {63'd0, idu_valid}, 64'd0);
            end
            if (ireq_valid && iresp_ready && !rst) begin
                $display("bus  req addr=%h data=%h", ireq_addr, iresp_data);
                if (exp_addr.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_req: got addr %h expected no request", ireq_addr);
                end else begin
                    chk("req_addr", ireq_addr, exp_addr.pop_front());
                end
            end
            if (idu_valid) begin
                $display("idu  pc=%h instr=%h cnt=%0d", pc, instr, fetch_cnt);
                if (exp_idu.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_idu: got pc %h expected no pulse", pc);
                end else begin
                    e = exp_idu.pop_front();
                    chk("idu_pc", pc, e.pc);
                    chk("idu_instr", {32'd0, instr}, {32'd0, e.instr});
                    chk("idu_cnt", fetch_cnt, e.cnt);
                end
            end
            prev_pending = ireq_valid && !iresp_ready && !rst;
            prev_addr    = ireq_addr;
            prev_idu     = idu_valid;
        end
    end

    task automatic wait_idu(input string tag);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (idu_valid) begin
                seen = 1'b1;
                break;
            end
        end
        n_checks++;
        if (!seen) begin
            n_fail++;
            $display("FAIL %s: got no idu_valid expected pulse within 60 cycles", tag);
        end
    endtask

    // Drives the EXEC-stage inputs for exactly one cycle, returns at the next negedge.
    task automatic pulse_exec(input logic w, input logic bt, input logic [63:0] bta,
                              input logic fl, input logic [63:0] fpc);
        wb_done   = w;
        br_taken  = bt;
        br_target = bta;
        flush     = fl;
        flush_pc  = fpc;
        @(negedge clk);
        wb_done  = 1'b0;
        br_taken = 1'b0;
        flush    = 1'b0;
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_ireq_valid"}, {63'd0, ireq_valid}, 64'd0);
        chk({tag, "_ireq_addr"}, ireq_addr, 64'h8000_0000);
        chk({tag, "_pc"}, pc, 64'h8000_0000);
        chk({tag, "_instr"}, {32'd0, instr}, 64'd0);
        chk({tag, "_idu_valid"}, {63'd0, idu_valid}, 64'd0);
        chk({tag, "_fetch_err"}, {63'd0, fetch_err}, 64'd0);
        chk({tag, "_fetch_cnt"}, fetch_cnt, 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected end of test");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst       = 1'b1;
        wb_done   = 1'b0;
        br_taken  = 1'b0;
        br_target = '0;
        flush     = 1'b0;
        flush_pc  = '0;
        repeat (3) @(negedge clk);
        chk_reset_state("reset");

        // First fetch, zero-wait memory
        exp_addr.push_back(64'h8000_0000);
        exp_idu.push_back('{64'h8000_0000, 32'h0000_0013, 64'd1});
        rst = 1'b0;
        @(negedge clk);
        chk("first_req_valid", {63'd0, ireq_valid}, 64'd1);
        chk("first_req_addr", ireq_addr, 64'h8000_0000);
        wait_idu("first_fetch");

        // Sequential next PC
        exp_addr.push_back(64'h8000_0004);
        exp_idu.push_back('{64'h8000_0004, 32'h0000_4013, 64'd2});
        pulse_exec(1'b1, 1'b0, 64'h0, 1'b0, 64'h0);
        chk("seq_req_addr_m1", ireq_addr, 64'h8000_0004);
        chk("seq_req_valid_m1", {63'd0, ireq_valid}, 64'd1);
        wait_idu("seq_fetch");

        // Taken branch
        exp_addr.push_back(64'h8000_0100);
        exp_idu.push_back('{64'h8000_0100, 32'h0010_0013, 64'd3});
        pulse_exec(1'b1, 1'b1, 64'h8000_0100, 1'b0, 64'h0);
        chk("br_req_addr_m1", ireq_addr, 64'h8000_0100);
        wait_idu("branch_fetch");

        // Flush during a waited request: old request drains, then redirect
        mem_wait = 3;
        exp_addr.push_back(64'h8000_0104);
        exp_addr.push_back(64'h8000_0200);
        exp_idu.push_back('{64'h8000_0200, 32'h0020_0013, 64'd4});
        pulse_exec(1'b1, 1'b0, 64'h0, 1'b0, 64'h0);
        flush    = 1'b1;
        flush_pc = 64'h8000_0200;
        @(negedge clk);
        flush = 1'b0;
        chk("drain_req_valid", {63'd0, ireq_valid}, 64'd1);
        chk("drain_req_addr", ireq_addr, 64'h8000_0104);
        wait_idu("drain_fetch");

        // Flush beats a simultaneous wb_done
        mem_wait = 0;
        exp_addr.push_back(64'h8000_0300);
        exp_idu.push_back('{64'h8000_0300, 32'h0030_0013, 64'd5});
        pulse_exec(1'b1, 1'b0, 64'h0, 1'b1, 64'h8000_0300);
        chk("flush_prio_addr", ireq_addr, 64'h8000_0300);
        wait_idu("flush_prio_fetch");

        // Flush in the same cycle as the response: data dropped, refetch
        exp_addr.push_back(64'h8000_0304);
        exp_addr.push_back(64'h8000_0400);
        exp_idu.push_back('{64'h8000_0400, 32'h0040_0013, 64'd6});
        pulse_exec(1'b1, 1'b0, 64'h0, 1'b0, 64'h0);
        flush    = 1'b1;
        flush_pc = 64'h8000_0400;
        @(negedge clk);
        flush = 1'b0;
        chk("flush_resp_addr", ireq_addr, 64'h8000_0400);
        chk("flush_resp_no_idu", {63'd0, idu_valid}, 64'd0);
        wait_idu("flush_resp_fetch");

        // Misaligned branch target -> ERR
        pulse_exec(1'b1, 1'b1, 64'h8000_0102, 1'b0, 64'h0);
        chk("err_set", {63'd0, fetch_err}, 64'd1);
        chk("err_no_req", {63'd0, ireq_valid}, 64'd0);
        repeat (3) @(negedge clk);
        chk("err_idle_no_req", {63'd0, ireq_valid}, 64'd0);
        flush    = 1'b1;
        flush_pc = 64'h8000_0002;
        @(negedge clk);
        flush = 1'b0;
        chk("err_misaligned_flush", {63'd0, fetch_err}, 64'd1);
        chk("err_misaligned_no_req", {63'd0, ireq_valid}, 64'd0);
        exp_addr.push_back(64'h8000_0010);
        exp_idu.push_back('{64'h8000_0010, 32'h0001_0013, 64'd7});
        flush    = 1'b1;
        flush_pc = 64'h8000_0010;
        @(negedge clk);
        flush = 1'b0;
        chk("err_clear", {63'd0, fetch_err}, 64'd0);
        chk("err_resume_valid", {63'd0, ireq_valid}, 64'd1);
        chk("err_resume_addr", ireq_addr, 64'h8000_0010);
        wait_idu("err_resume_fetch");

        // Reset while a request is waiting
        mem_wait = 5;
        pulse_exec(1'b1, 1'b0, 64'h0, 1'b0, 64'h0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk_reset_state("midreq_reset");
        @(negedge clk);
        mem_wait = 0;
        exp_addr.push_back(64'h8000_0000);
        exp_idu.push_back('{64'h8000_0000, 32'h0000_0013, 64'd1});
        rst = 1'b0;
        wait_idu("after_reset_fetch");

        repeat (3) @(negedge clk);
        chk("req_queue_empty", 64'(exp_addr.size()), 64'd0);
        chk("idu_queue_empty", 64'(exp_idu.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
